// File: rtl/seq_multiplier.sv
// ============================================================================
// seq_multiplier
// ----------------------------------------------------------------------------
// Sequential 8x8 shift-add multiplier with accumulate:
//     product = multiplicand * multiplier + addend      (all unsigned)
//
// One operation takes 10 edges:
//     E0     accept (IDLE, start=1): operands are captured.
//     E1-E8  eight shift-add iterations (ITER).
//     E9     the addend is folded in, product is loaded and done pulses (ADD).
//
// This is the inverse datapath of the restoring divider. Feeding it the
// divider's quotient, divisor and remainder gives back the dividend.
//
// Ports
//     clk           in   1   single clock, rising edge
//     rstn          in   1   asynchronous active-low reset
//     start         in   1   request an operation; sampled only in IDLE
//     multiplicand  in   8   operand M, captured on the accepting edge
//     multiplier    in   8   operand Q, captured on the accepting edge
//     addend        in   8   value added to M*Q, captured on the accepting edge
//     busy          out  1   high while state != IDLE
//     done          out  1   one-cycle pulse; product is valid from this cycle
//     product       out  16  result; held until the next completion
// ============================================================================
module seq_multiplier (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    input  logic [7:0]  addend,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        ADD  = 2'b10
    } state_t;

    state_t      state;
    logic [7:0]  m_reg;
    logic [7:0]  add_reg;
    logic        c;
    logic [7:0]  a_reg;
    logic [7:0]  q_reg;
    logic [2:0]  count;

    logic        count_full;
    logic [7:0]  partial;
    logic [8:0]  iter_sum;

    assign count_full = (count == 3'd7);

    // busy comes from the registered state only, so start never reaches it
    // combinationally.
    assign busy = (state != IDLE);

    // One shift-add step: add M into the accumulator when the current
    // multiplier bit is set. The stored carry is always zero between steps
    // (it is shifted into a_reg every iteration); it sits in the MSB of the
    // 9-bit add so the datapath reads as the classic {C,A,Q} register.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis would infer a latch to hold the old value.
        partial  = 8'd0;
        if (q_reg[0]) begin
            partial = m_reg;
        end
        iter_sum = {c, a_reg} + {1'b0, partial};
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            m_reg   <= 8'd0;
            add_reg <= 8'd0;
            c       <= 1'b0;
            a_reg   <= 8'd0;
            q_reg   <= 8'd0;
            count   <= 3'd0;
            product <= 16'h0000;
            done    <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the ADD edge re-asserts it.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg   <= multiplicand;
                        add_reg <= addend;
                        q_reg   <= multiplier;
                        a_reg   <= 8'd0;
                        c       <= 1'b0;
                        count   <= 3'd0;
                        state   <= ITER;
                    end
                end

                ITER: begin
                    // Shift {carry, sum, q} right by one: the carry enters
                    // the top of a_reg and the sum's LSB becomes a new low
                    // product bit at the top of q_reg.
                    c     <= 1'b0;
                    a_reg <= iter_sum[8:1];
                    q_reg <= {iter_sum[0], q_reg[7:1]};
                    count <= count + 3'd1;
                    if (count_full) begin
                        state <= ADD;
                    end
                end

                ADD: begin
                    // 255*255 + 255 = 65280 fits in 16 bits; no overflow.
                    product <= {a_reg, q_reg} + {8'd0, add_reg};
                    done    <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    // Unused encoding 2'b11 recovers to IDLE.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// tb_seq_multiplier
// ----------------------------------------------------------------------------
// Self-checking bench for seq_multiplier. Expected results come from plain
// integer arithmetic (m * q + a); timing expectations come from the
// documented edge schedule (done 9 clocks after the accepting edge, busy
// high for 9 sampled cycles).
// ============================================================================
module tb_seq_multiplier;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [7:0]  addend;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;

    seq_multiplier dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge: outputs are stable
    // there and inputs driven here are set up well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] ref_mac(input logic [7:0] m,
                                            input logic [7:0] q,
                                            input logic [7:0] a);
        int r;
        r = int'(m) * int'(q) + int'(a);
        return r[15:0];
    endfunction

    // Runs one operation starting from a drive point (just after an edge).
    // Operands are scrambled every cycle while busy; with noisy set, start
    // is also pulsed with fresh operands mid-operation. Returns with the
    // bench sitting in the cycle where done is high.
    task automatic do_op(input string tag, input logic [7:0] m,
                         input logic [7:0] q, input logic [7:0] a,
                         input bit noisy);
        logic [15:0] exp_p;
        int          lat;
        int          busy_cycles;
        exp_p        = ref_mac(m, q, a);
        multiplicand = m;
        multiplier   = q;
        addend       = a;
        start        = 1'b1;
        step();
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            start        = noisy && (lat == 3 || lat == 6);
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            addend       = 8'($urandom);
            step();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_cycles, 9);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_product"}, product, exp_p);
    endtask

    initial begin
        int          dones;
        logic [7:0]  quo;
        logic [7:0]  dvs;
        logic [7:0]  rem;
        logic [15:0] held;

        rstn         = 1'b0;
        start        = 1'b0;
        multiplicand = 8'd0;
        multiplier   = 8'd0;
        addend       = 8'd0;
        step();
        step();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_product", product, 16'h0000);
        rstn = 1'b1;
        step();

        // Basic operation and corner operands.
        do_op("op_13x11p7", 8'd13, 8'd11, 8'd7, 1'b0);
        check("op_13x11p7_const", product, 16'h0096);
        step();
        check("done_one_cycle", done, 1'b0);
        do_op("op_max", 8'd255, 8'd255, 8'd255, 1'b0);
        check("op_max_const", product, 16'hFF00);
        step();
        do_op("op_zero", 8'd0, 8'd200, 8'd0, 1'b0);
        step();
        do_op("op_1x200p9", 8'd1, 8'd200, 8'd9, 1'b0);
        check("op_1x200p9_const", product, 16'h00D1);
        step();
        do_op("op_128x2", 8'd128, 8'd2, 8'd0, 1'b0);
        check("op_128x2_const", product, 16'h0100);
        step();

        // start pulses while busy are ignored and not queued.
        do_op("op_noisy", 8'd57, 8'd93, 8'd18, 1'b1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) dones++;
        end
        check("noisy_extra_done", dones, 0);
        check("noisy_idle", busy, 1'b0);
        check("noisy_product_held", product, ref_mac(8'd57, 8'd93, 8'd18));

        // Back-to-back: start in the done cycle of the previous op.
        do_op("b2b_first", 8'd20, 8'd30, 8'd40, 1'b0);
        do_op("b2b_second", 8'd7, 8'd9, 8'd4, 1'b0);
        check("b2b_second_const", product, 16'h0043);
        held = product;
        step();
        check("b2b_done_clear", done, 1'b0);
        check("b2b_product_hold", product, held);

        // Asynchronous reset in the middle of an operation.
        multiplicand = 8'd99;
        multiplier   = 8'd77;
        addend       = 8'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_product", product, 16'h0000);
        step();
        step();
        #2;
        rstn = 1'b1;
        step();
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            step();
        end
        check("abandoned_no_done", dones, 0);
        check("abandoned_idle", busy, 1'b0);
        do_op("after_rst_3x3", 8'd3, 8'd3, 8'd0, 1'b0);
        check("after_rst_3x3_const", product, 16'h0009);
        step();

        // Divider round trip: quotient * divisor + remainder, remainder < divisor.
        for (int i = 0; i < 200; i++) begin
            quo = 8'($urandom);
            dvs = 8'($urandom_range(255, 1));
            rem = 8'($urandom_range(int'(dvs) - 1, 0));
            do_op("roundtrip", quo, dvs, rem, 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential 8x8 shift-add multiplier with accumulate. It computes `product = multiplicand * multiplier + addend` over a fixed number of cycles. It is the inverse datapath of the restoring divider: feeding it the divider's quotient, divisor and remainder reconstructs the dividend. It sits beside the divider in the arithmetic unit, both as a standalone multiplier and as a self-check partner in divider benches.

## Interface
- No parameters. The width is fixed at 8-bit operands and a 16-bit result.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a new operation. Sampled only in IDLE.
- `multiplicand`  input  8  unsigned operand M. Captured on the accepting edge.
- `multiplier`  input  8  unsigned operand Q. Captured on the accepting edge.
- `addend`  input  8  unsigned value added to the product. Captured on the accepting edge.
- `busy`  output  1  high while an operation is in flight (state != IDLE).
- `done`  output  1  one-cycle registered pulse; `product` is valid from this cycle on.
- `product`  output  16  registered result. Holds its value until the next completion.

## Operation
- Registers:
  - `m_reg[7:0]`, `add_reg[7:0]`: captured operands.
  - `c` (1 bit), `a_reg[7:0]`, `q_reg[7:0]`: accumulator, carry and multiplier/low-product shift register.
  - `count[2:0]` with `count_full = (count == 7)`.
  - `state[1:0]`, `product[15:0]`, `done`.
- States:
  - IDLE = 2'b00.
  - ITER = 2'b01.
  - ADD = 2'b10.
  - 2'b11 is unused and recovers to IDLE on the next edge.
- IDLE, `start=1`:
  - Capture `m_reg<=multiplicand`, `add_reg<=addend`, `q_reg<=multiplier`.
  - Clear `a_reg<=0`, `c<=0`, `count<=0`.
  - Go to ITER.
- IDLE, `start=0`: all registers hold.
- ITER, every edge:
  - `{c,sum} = a_reg + (q_reg[0] ? m_reg : 0)`, a 9-bit add.
  - Shift right: `{c,a_reg,q_reg} <= {1'b0, c_sum, sum, q_reg[7:1]}`. In other words, the new `a_reg = {carry, sum[7:1]}` and the new `q_reg = {sum[0], q_reg[7:1]}`.
  - `count<=count+1`.
  - If `count_full`, go to ADD; otherwise stay in ITER.
  - This gives exactly 8 iterations.
- ADD, one edge:
  - `product <= {a_reg,q_reg} + {8'd0,add_reg}`.
  - `done<=1`.
  - Go to IDLE.
- `done` is cleared on every edge where it is not being set.
- Arithmetic:
  - Unsigned throughout.
  - Maximum result is 255*255+255 = 65280, so the 16-bit add never overflows. No overflow flag.
- Operand inputs are ignored while `busy`. Changes mid-operation do not affect the result.
- `start` while `busy`: ignored and not queued.
- `start` in the cycle `done` is high: accepted, because state is already IDLE. `done` still deasserts on the next edge.

## Timing
- Reset (`rstn=0`, asynchronous, any state) clears:
  - `state=IDLE`, `busy=0`, `done=0`, `product=16'h0000`.
  - `count=0`, `a_reg=q_reg=m_reg=add_reg=0`, `c=0`.
  - Any in-flight operation is abandoned. No `done` is produced for it.
- Accepting edge E0 (IDLE, `start=1`). `busy` goes high after E0.
- Edges E1 to E8: the 8 ITER iterations.
- Edge E9 (ADD):
  - `product` updates and `done=1` for the cycle after E9.
  - `busy=0` after E9.
- Latency:
  - Start edge to `done` edge: 9 clocks.
  - Minimum issue interval: 10 clocks, since a new `start` can be accepted on E10.
- `product` is stable from E9 until the next operation's ADD edge. It is never cleared by `start`.
- `busy` is decoded from the registered `state` only. There is no combinational path from `start`.

## Test plan
- Reset, then 13 * 11 + 7: `done` pulses exactly 9 clocks after the start edge, `product = 16'h0096` (150), and `busy` is high for exactly 9 cycles.
- 255 * 255 + 255 gives `product = 16'hFF00` (65280). 0 * 200 + 0 gives `16'h0000`. 1 * 200 + 9 gives `16'h00D1` (209). 128 * 2 + 0 gives `16'h0100`.
- Pulse `start` with new operands on cycles 3 and 6 of a busy operation: both are ignored, the first result is unaffected, and there is only one `done`.
- Assert `start` (7 * 9 + 4) in the same cycle `done` is high for the previous operation: the new operation is accepted, and the second `done` arrives 9 clocks later with `product = 16'h0043` (67).
- Drop `rstn` at cycle 4 of an operation: `busy`, `done` and `product` go to 0 immediately (asynchronously), and no `done` appears afterwards. After release, a new 3 * 3 + 0 completes with 9.
- Divider round trip: for 200 random (quotient, divisor, remainder) triples with remainder < divisor, `product` equals `quotient * divisor + remainder` every time.
